// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - frame buffer scanout: screen-to-memory mapping and read pipeline (option: VGA_FB_SCANOUT_DBLBUF_EN)
package vga_fb_pkg;
   localparam int unsigned X_PIXEL_MEM = 97;
   localparam int unsigned Y_PIXEL_MEM = 257;

   typedef logic [7:0] raw_pixel_t;
   typedef raw_pixel_t render_pixel_t;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       active;
      logic [9:0] pixel_x;
      logic [9:0] pixel_y;
   } vga_ctrl_t;

   typedef struct packed {
      vga_ctrl_t  ctrl;
      raw_pixel_t pixel;
   } mem_pixel_t;

   localparam mem_pixel_t mem_pixel_dv = '{
      ctrl  : '{hs: 1'b1, vs: 1'b1, active: 1'b0, pixel_x: 10'd0, pixel_y: 10'd0},
      pixel : 8'h00
   };
endpackage

module vga_fb_scanout
   import vga_fb_pkg::*;
#(
   parameter int unsigned H_SCALE = 2,
   parameter int unsigned V_SCALE = 4,
   parameter raw_pixel_t  BORDER  = 8'h00,
   parameter int unsigned ADDR_W  = $clog2(X_PIXEL_MEM * Y_PIXEL_MEM)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  vga_ctrl_t         in_ctrl,
   output logic              rd_en,
`ifdef VGA_FB_SCANOUT_DBLBUF_EN
   output logic [ADDR_W:0]   rd_addr,
   input  logic              bank_sel,
`else
   output logic [ADDR_W-1:0] rd_addr,
`endif
   input  raw_pixel_t        rd_data,
   output logic              out_valid,
   output mem_pixel_t        out_pix
);

   localparam int unsigned HPH_W = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
   localparam int unsigned VPH_W = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
   localparam int unsigned MX_W  = $clog2(X_PIXEL_MEM + 1);
   localparam int unsigned MY_W  = $clog2(Y_PIXEL_MEM + 1);
`ifdef VGA_FB_SCANOUT_DBLBUF_EN
   localparam int unsigned RD_W  = ADDR_W + 1;
`else
   localparam int unsigned RD_W  = ADDR_W;
`endif

   logic [HPH_W-1:0]  h_ph, h_ph_nxt;
   logic [VPH_W-1:0]  v_ph, v_ph_nxt;
   logic [MY_W-1:0]   mem_y, mem_y_nxt;
   logic [MX_W-1:0]   mem_x, mem_x_nxt;
   logic [ADDR_W-1:0] row_base, row_base_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [RD_W-1:0]   rd_addr_full;
   logic [RD_W-1:0]   rd_addr_q;
   logic [9:0]        last_y;
   logic              line_start;
   logic              frame_start;
   logic              in_window;

   logic              s1_valid;
   logic              s1_rd;
   vga_ctrl_t         s1_ctrl;

   assign line_start  = (in_ctrl.pixel_x == 10'd0);
   assign frame_start = line_start && (in_ctrl.pixel_y == 10'd0);

   // Next counter values for this beat; the beat itself uses the updated values
   always_comb begin
      h_ph_nxt     = h_ph;
      mem_y_nxt    = mem_y;
      v_ph_nxt     = v_ph;
      mem_x_nxt    = mem_x;
      row_base_nxt = row_base;
      if (in_valid) begin
         if (line_start) begin
            h_ph_nxt  = '0;
            mem_y_nxt = '0;
         end else if (in_ctrl.active) begin
            if (h_ph == HPH_W'(H_SCALE - 1)) begin
               h_ph_nxt = '0;
               if (mem_y != MY_W'(Y_PIXEL_MEM))
                  mem_y_nxt = mem_y + 1'b1;
            end else begin
               h_ph_nxt = h_ph + 1'b1;
            end
         end
         if (in_ctrl.pixel_y == 10'd0) begin
            v_ph_nxt     = '0;
            mem_x_nxt    = '0;
            row_base_nxt = '0;
         end else if (line_start && (in_ctrl.pixel_y != last_y)) begin
            if (v_ph == VPH_W'(V_SCALE - 1)) begin
               v_ph_nxt = '0;
               // row_base stops with mem_x so it can never overflow its width
               if (mem_x != MX_W'(X_PIXEL_MEM)) begin
                  mem_x_nxt    = mem_x + 1'b1;
                  row_base_nxt = row_base + ADDR_W'(Y_PIXEL_MEM);
               end
            end else begin
               v_ph_nxt = v_ph + 1'b1;
            end
         end
      end
   end

`ifdef VGA_FB_SCANOUT_DBLBUF_EN
   logic bank, bank_nxt;

   // Bank only switches at the top-left beat so a frame never mixes banks
   always_comb begin
      bank_nxt = bank;
      if (in_valid && frame_start)
         bank_nxt = bank_sel;
   end

   // Displayed bank register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bank <= 1'b0;
      else        bank <= bank_nxt;
   end

   assign rd_addr_full = {bank_nxt, addr_nxt};
`else
   assign rd_addr_full = addr_nxt;
`endif

   // Window test and read request; the RAM registers the address this cycle
   always_comb begin
      addr_nxt  = row_base_nxt + ADDR_W'(mem_y_nxt);
      in_window = in_ctrl.active && (mem_x_nxt < MX_W'(X_PIXEL_MEM))
                                 && (mem_y_nxt < MY_W'(Y_PIXEL_MEM));
      rd_en     = rst_n && in_valid && in_window;
      rd_addr   = rd_en ? rd_addr_full : rd_addr_q;
   end

   // Mapping counters, previous line number and held read address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_ph      <= '0;
         v_ph      <= '0;
         mem_y     <= '0;
         mem_x     <= '0;
         row_base  <= '0;
         last_y    <= '0;
         rd_addr_q <= '0;
      end else begin
         h_ph      <= h_ph_nxt;
         v_ph      <= v_ph_nxt;
         mem_y     <= mem_y_nxt;
         mem_x     <= mem_x_nxt;
         row_base  <= row_base_nxt;
         rd_addr_q <= rd_addr;
         if (in_valid)
            last_y <= in_ctrl.pixel_y;
      end
   end

   // S1: carry ctrl, valid and read flag while the RAM access is in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_rd    <= 1'b0;
         s1_ctrl  <= mem_pixel_dv.ctrl;
      end else begin
         s1_valid <= in_valid;
         s1_rd    <= rd_en;
         s1_ctrl  <= in_ctrl;
      end
   end

   // S2: join ctrl with RAM data, or BORDER where no read was issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_pix   <= mem_pixel_dv;
      end else begin
         out_valid     <= s1_valid;
         out_pix.ctrl  <= s1_ctrl;
         out_pix.pixel <= s1_rd ? rd_data : BORDER;
      end
   end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb/tb_vga_fb_scanout.sv - directed vector bench for vga_fb_scanout
module tb_vga_fb_scanout;
   import vga_fb_pkg::*;

`ifdef VGA_FB_SCANOUT_DBLBUF_EN
   localparam int RD_W = 16;
`else
   localparam int RD_W = 15;
`endif
   localparam raw_pixel_t BORDER = 8'h00;

   typedef struct {
      logic v;
      logic act;
      int   x;
      int   y;
      logic en;
      int   addr;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   vga_ctrl_t       in_ctrl;
   logic            rd_en;
   logic [RD_W-1:0] rd_addr;
   raw_pixel_t      rd_data;
   logic            out_valid;
   mem_pixel_t      out_pix;
`ifdef VGA_FB_SCANOUT_DBLBUF_EN
   logic            bank_sel;
`endif

   int              n_vec = 0;
   int              n_bad = 0;
   logic [RD_W-1:0] hold_addr;
   logic            exp_bank;
   logic            pipe_val [2];
   mem_pixel_t      pipe_pix [2];
   vec_t            tbl [$];

   vga_fb_scanout dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ctrl   (in_ctrl),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
`ifdef VGA_FB_SCANOUT_DBLBUF_EN
      .bank_sel  (bank_sel),
`endif
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_pix   (out_pix)
   );

   always #5 clk = ~clk;

   function automatic raw_pixel_t ram_val(input logic [RD_W-1:0] a);
      logic [15:0] w;
      w = 16'(a);
      return w[7:0] ^ w[15:8] ^ 8'hA5;
   endfunction

   // sync RAM model: data one clock after the read request
   always @(posedge clk)
      if (rd_en) rd_data <= ram_val(rd_addr);

   function automatic logic [RD_W-1:0] full_addr(input int a);
`ifdef VGA_FB_SCANOUT_DBLBUF_EN
      return {exp_bank, 15'(a)};
`else
      return RD_W'(a);
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic pipe_reset();
      for (int i = 0; i < 2; i++) begin
         pipe_val[i] = 1'b0;
         pipe_pix[i] = mem_pixel_dv;
      end
   endtask

   task automatic step(input logic v, input logic act, input int x, input int y,
                       input logic en, input int addr);
      chk("out_valid", 32'(out_valid), 32'(pipe_val[1]));
      chk($sformatf("out_pix(beat %0d,%0d ago2)", x, y), 32'(out_pix), 32'(pipe_pix[1]));
      in_valid        = v;
      in_ctrl.hs      = ~x[0];
      in_ctrl.vs      = y[1];
      in_ctrl.active  = act;
      in_ctrl.pixel_x = 10'(x);
      in_ctrl.pixel_y = 10'(y);
      #1;
      chk($sformatf("rd_en(%0d,%0d)", x, y), 32'(rd_en), 32'(en));
      if (en) hold_addr = full_addr(addr);
      chk($sformatf("rd_addr(%0d,%0d)", x, y), 32'(rd_addr), 32'(hold_addr));
      pipe_val[1]       = pipe_val[0];
      pipe_pix[1]       = pipe_pix[0];
      pipe_val[0]       = v;
      pipe_pix[0].ctrl  = in_ctrl;
      pipe_pix[0].pixel = en ? ram_val(hold_addr) : BORDER;
      @(negedge clk);
   endtask

   task automatic add(input logic v, input logic act, input int x, input int y,
                      input logic en, input int addr);
      vec_t t;
      t.v = v; t.act = act; t.x = x; t.y = y; t.en = en; t.addr = addr;
      tbl.push_back(t);
   endtask

   initial begin
      // row 0 horizontal scaling, a valid gap and an inactive beat
      add(1, 1, 0, 0, 1, 0);
      add(1, 1, 1, 0, 1, 0);
      add(1, 1, 2, 0, 1, 1);
      add(1, 1, 3, 0, 1, 1);
      add(1, 1, 4, 0, 1, 2);
      add(1, 1, 5, 0, 1, 2);
      add(0, 1, 6, 0, 0, 0);
      add(1, 1, 6, 0, 1, 3);
      add(1, 0, 7, 0, 0, 0);
      add(1, 1, 8, 0, 1, 3);
      add(1, 1, 9, 0, 1, 4);
      // vertical scaling and a repeated line start
      add(1, 1, 0, 1, 1, 0);
      add(1, 1, 1, 1, 1, 0);
      add(1, 1, 0, 2, 1, 0);
      add(1, 1, 0, 3, 1, 0);
      add(1, 1, 0, 4, 1, 257);
      add(1, 1, 1, 4, 1, 257);
      add(1, 1, 2, 4, 1, 258);
      add(1, 1, 0, 4, 1, 257);
      add(1, 0, 0, 5, 0, 0);
      add(1, 1, 1, 5, 1, 257);

      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = '{hs: 1'b0, vs: 1'b0, active: 1'b1, pixel_x: 10'd0, pixel_y: 10'd0};
      hold_addr = '0;
      exp_bank  = 1'b0;
`ifdef VGA_FB_SCANOUT_DBLBUF_EN
      bank_sel  = 1'b0;
`endif
      pipe_reset();
      repeat (3) @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_pix", 32'(out_pix), 32'(mem_pixel_dv));
      chk("reset rd_en", 32'(rd_en), 32'd0);
      chk("reset rd_addr", 32'(rd_addr), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].v, tbl[i].act, tbl[i].x, tbl[i].y, tbl[i].en, tbl[i].addr);

      // full sweep down to line 387, then across it past the window edge
      step(1, 1, 0, 0, 1, 0);
      for (int y = 1; y <= 387; y++)
         step(1, 1, 0, y, 1, (y / 4) * 257);
      for (int x = 1; x <= 515; x++)
         step(1, 1, x, 387, (x / 2) < 257, 96 * 257 + x / 2);
      step(1, 1, 0, 388, 0, 0);
      step(1, 1, 1, 388, 0, 0);
      step(1, 1, 2, 388, 0, 0);

      // mid-frame jump stays outside the window until the (0,0) beat
      step(1, 1, 200, 40, 0, 0);
      step(1, 1, 0, 0, 1, 0);
      step(1, 1, 1, 0, 1, 0);
      step(1, 1, 2, 0, 1, 1);
      step(1, 1, 3, 0, 1, 1);

      // asynchronous reset mid-line
      in_valid        = 1'b1;
      in_ctrl.pixel_x = 10'd4;
      in_ctrl.active  = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("midreset out_valid", 32'(out_valid), 32'd0);
      chk("midreset out_pix", 32'(out_pix), 32'(mem_pixel_dv));
      chk("midreset rd_en", 32'(rd_en), 32'd0);
      chk("midreset rd_addr", 32'(rd_addr), 32'd0);
      hold_addr = '0;
      pipe_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 1, 0, 0, 1, 0);
      step(1, 1, 1, 0, 1, 0);
      step(1, 1, 2, 0, 1, 1);
      step(1, 1, 3, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

`ifdef VGA_FB_SCANOUT_DBLBUF_EN
      // bank request mid-frame takes effect only at the next (0,0) beat
      bank_sel = 1'b1;
      step(1, 1, 4, 0, 1, 2);
      step(1, 1, 0, 1, 1, 0);
      step(1, 1, 1, 1, 1, 0);
      exp_bank = 1'b1;
      step(1, 1, 0, 0, 1, 0);
      chk("bank msb", 32'(rd_addr), 32'h8000);
      step(1, 1, 1, 0, 1, 0);
      step(1, 1, 2, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
